// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer and its return-address stack.
package pc_pkg;

    localparam int unsigned PC_MAX_W = 64;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_CALL,
        PC_RET,
        PC_SWAP,
        PC_TRAP,
        PC_HOLD
    } pc_src_t;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPLACE
    } ras_op_t;

    // Clears the low log2(step) bits; step must be a power of two.
    function automatic logic [PC_MAX_W-1:0] align_addr(input logic [PC_MAX_W-1:0] addr,
                                                       input int unsigned         step);
        logic [PC_MAX_W-1:0] w_mask;
        w_mask = PC_MAX_W'(step) - PC_MAX_W'(1);
        return addr & ~w_mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch controller and the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic             en;
    logic             branchFlag;
    logic             callFlag;
    logic             retFlag;
    logic             trapFlag;
    logic [WIDTH-1:0] branchAddr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcPlus;
    logic [CW-1:0]    rasCount;
    logic             rasUnderflow;
    logic             misaligned;

    modport master (
        output en, branchFlag, callFlag, retFlag, trapFlag, branchAddr,
        input  pc, pcPlus, rasCount, rasUnderflow, misaligned
    );

    modport slave (
        input  en, branchFlag, callFlag, retFlag, trapFlag, branchAddr,
        output pc, pcPlus, rasCount, rasUnderflow, misaligned
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: pushes past full overwrite the oldest entry, count saturates.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ras_op_t                i_op,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_top,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [PW:0]      r_count;
    logic [PW-1:0]    w_top_inc;

    // Depth is a power of two, so the pointer wraps naturally.
    assign w_top_inc = r_top + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else begin
            case (i_op)
                RAS_PUSH: begin
                    r_top <= w_top_inc;
                    if (r_count != FULL) r_count <= r_count + (PW + 1)'(1);
                end
                RAS_POP: begin
                    if (r_count != '0) begin
                        r_top   <= r_top - PW'(1);
                        r_count <= r_count - (PW + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            case (i_op)
                RAS_PUSH:    r_mem[w_top_inc] <= i_data;
                RAS_REPLACE: r_mem[r_top]     <= i_data;
                default: ;
            endcase
        end
    end

    assign o_top   = r_mem[r_top];
    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority-selects sequential/branch/call/return/trap each cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_misaligned;
    logic             r_underflow;

    pc_src_t          w_src;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_mis;
    logic             w_under;
    ras_op_t          w_ras_op;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_ret_addr;
    logic [WIDTH-1:0] w_target;
    logic             w_target_mis;
    logic [WIDTH-1:0] w_top;
    logic [CW-1:0]    w_count;
    logic             w_ras_nonempty;

    assign w_pc_plus      = r_pc + WIDTH'(STEP);
    assign w_ret_addr     = WIDTH'(align_addr(PC_MAX_W'(w_pc_plus), STEP));
    assign w_target       = WIDTH'(align_addr(PC_MAX_W'(bus.branchAddr), STEP));
    assign w_target_mis   = (w_target != bus.branchAddr);
    assign w_ras_nonempty = (w_count != '0);

    always_comb begin
        w_src = PC_SEQ;
        if (bus.trapFlag)                       w_src = PC_TRAP;
        else if (!bus.en)                       w_src = PC_HOLD;
        else if (bus.retFlag && bus.callFlag)   w_src = w_ras_nonempty ? PC_SWAP : PC_CALL;
        else if (bus.retFlag)                   w_src = PC_RET;
        else if (bus.callFlag)                  w_src = PC_CALL;
        else if (bus.branchFlag)                w_src = PC_BRANCH;
    end

    always_comb begin
        w_next_pc = r_pc;
        w_mis     = 1'b0;
        w_under   = 1'b0;
        w_ras_op  = RAS_NONE;
        case (w_src)
            PC_SEQ:    w_next_pc = w_pc_plus;
            PC_BRANCH: begin
                w_next_pc = w_target;
                w_mis     = w_target_mis;
            end
            PC_CALL: begin
                w_next_pc = w_target;
                w_mis     = w_target_mis;
                w_ras_op  = RAS_PUSH;
            end
            PC_RET: begin
                if (w_ras_nonempty) begin
                    w_next_pc = w_top;
                    w_ras_op  = RAS_POP;
                end else begin
                    w_next_pc = w_pc_plus;
                    w_under   = 1'b1;
                end
            end
            PC_SWAP: begin
                w_next_pc = w_top;
                w_ras_op  = RAS_REPLACE;
            end
            PC_TRAP:   w_next_pc = TRAP_VECTOR;
            default:   w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            r_misaligned <= w_mis;
            r_underflow  <= w_under;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_op    (w_ras_op),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_count (w_count)
    );

    assign bus.pc           = r_pc;
    assign bus.pcPlus       = w_pc_plus;
    assign bus.rasCount     = w_count;
    assign bus.rasUnderflow = r_underflow;
    assign bus.misaligned   = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, corner sequences, and random run against a queue model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) b32 ();
    pc_sequencer_if #(.WIDTH(16), .RAS_DEPTH(4)) b16 ();

    pc_sequencer #(.WIDTH(32), .STEP(4), .RAS_DEPTH(4)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    pc_sequencer #(.WIDTH(16), .STEP(4), .RAS_DEPTH(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    typedef struct {
        bit          en, br, ca, re, tr;
        logic [31:0] addr;
        logic [31:0] pc;
        int          cnt;
        bit          und, mis;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input bit en, br, ca, re, tr, input logic [31:0] addr,
                        input logic [31:0] pc, input int cnt, input bit und, mis);
        vec_t v;
        v.en = en; v.br = br; v.ca = ca; v.re = re; v.tr = tr; v.addr = addr;
        v.pc = pc; v.cnt = cnt; v.und = und; v.mis = mis;
        vt.push_back(v);
    endtask

    task automatic drive(input bit en, br, ca, re, tr, input logic [31:0] addr);
        b32.en = en; b32.branchFlag = br; b32.callFlag = ca;
        b32.retFlag = re; b32.trapFlag = tr; b32.branchAddr = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: return stack as a queue, most recent at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_und, m_mis;

    task automatic model_step(input bit r, en, br, ca, re, tr, input logic [31:0] a);
        logic [31:0] plus, tgt;
        plus  = m_pc + 32'd4;
        tgt   = a & ~32'd3;
        m_und = 0;
        m_mis = 0;
        if (r) begin
            m_pc = 32'h0;
            m_ras.delete();
        end else if (tr) begin
            m_pc = 32'h100;
        end else if (!en) begin
            m_pc = m_pc;
        end else if (re && m_ras.size() > 0) begin
            if (ca) begin
                m_pc = m_ras[m_ras.size() - 1];
                m_ras[m_ras.size() - 1] = plus;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (re && !ca) begin
            m_pc  = plus;
            m_und = 1;
        end else if (ca) begin
            m_mis = (a != tgt);
            m_pc  = tgt;
            m_ras.push_back(plus);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (br) begin
            m_mis = (a != tgt);
            m_pc  = tgt;
        end else begin
            m_pc = plus;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        b16.en = 0; b16.branchFlag = 0; b16.callFlag = 0;
        b16.retFlag = 0; b16.trapFlag = 0; b16.branchAddr = 16'h0;

        tick();
        check("reset_pc", 64'(b32.pc), 64'h0);
        check("reset_cnt", 64'(b32.rasCount), 64'h0);
        check("reset_und", 64'(b32.rasUnderflow), 64'h0);
        check("reset_mis", 64'(b32.misaligned), 64'h0);
        check("reset_pcplus", 64'(b32.pcPlus), 64'h4);
        rst = 1'b0;

        //    en br ca re tr addr          pc          cnt und mis
        addv(1, 0, 0, 0, 0, 32'h0,     32'h4,     0, 0, 0);
        addv(1, 0, 0, 0, 0, 32'h0,     32'h8,     0, 0, 0);
        addv(1, 0, 0, 0, 0, 32'h0,     32'hC,     0, 0, 0);
        addv(1, 0, 0, 0, 0, 32'h0,     32'h10,    0, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h200,   32'h200,   1, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h14,    0, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h18,    0, 1, 0);
        addv(1, 0, 0, 0, 0, 32'h0,     32'h1C,    0, 0, 0);
        addv(1, 1, 0, 0, 0, 32'h103,   32'h100,   0, 0, 1);
        addv(1, 0, 0, 0, 0, 32'h0,     32'h104,   0, 0, 0);
        addv(0, 1, 0, 0, 0, 32'h400,   32'h104,   0, 0, 0);
        addv(0, 1, 0, 0, 0, 32'h400,   32'h104,   0, 0, 0);
        addv(0, 1, 0, 0, 0, 32'h400,   32'h104,   0, 0, 0);
        addv(0, 0, 0, 0, 1, 32'h0,     32'h100,   0, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h1000,  32'h1000,  1, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h2000,  32'h2000,  2, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h3000,  32'h3000,  3, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h4000,  32'h4000,  4, 0, 0);
        addv(1, 0, 1, 0, 0, 32'h5000,  32'h5000,  4, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h4004,  3, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h3004,  2, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h2004,  1, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h1004,  0, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h1008,  0, 1, 0);
        addv(1, 0, 1, 1, 0, 32'h600,   32'h600,   1, 0, 0);
        addv(1, 0, 1, 1, 0, 32'h700,   32'h100C,  1, 0, 0);
        addv(1, 0, 0, 1, 0, 32'h0,     32'h604,   0, 0, 0);
        addv(1, 1, 1, 0, 1, 32'h802,   32'h100,   0, 0, 0);
        addv(1, 1, 0, 1, 0, 32'h900,   32'h104,   0, 1, 0);

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].br, vt[i].ca, vt[i].re, vt[i].tr, vt[i].addr);
            tick();
            check($sformatf("vec%0d_pc", i), 64'(b32.pc), 64'(vt[i].pc));
            check($sformatf("vec%0d_cnt", i), 64'(b32.rasCount), 64'(vt[i].cnt));
            check($sformatf("vec%0d_und", i), 64'(b32.rasUnderflow), 64'(vt[i].und));
            check($sformatf("vec%0d_mis", i), 64'(b32.misaligned), 64'(vt[i].mis));
        end

        // Reset in the middle of a call chain.
        drive(1, 0, 1, 0, 0, 32'h900);
        tick();
        drive(1, 0, 1, 0, 0, 32'hA03);
        tick();
        check("midrst_pre_cnt", 64'(b32.rasCount), 64'h2);
        check("midrst_pre_mis", 64'(b32.misaligned), 64'h1);
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 32'hB01);
        tick();
        rst = 1'b0;
        check("midrst_pc", 64'(b32.pc), 64'h0);
        check("midrst_cnt", 64'(b32.rasCount), 64'h0);
        check("midrst_mis", 64'(b32.misaligned), 64'h0);
        check("midrst_und", 64'(b32.rasUnderflow), 64'h0);
        drive(0, 0, 0, 0, 0, 32'h0);

        // 16-bit instance: sequential step off the top of the address space.
        b16.en = 1; b16.branchFlag = 1; b16.branchAddr = 16'hFFFC;
        tick();
        check("w16_pc_top", 64'(b16.pc), 64'hFFFC);
        check("w16_pcplus", 64'(b16.pcPlus), 64'h0);
        b16.branchFlag = 0;
        tick();
        check("w16_wrap_pc", 64'(b16.pc), 64'h0);
        check("w16_wrap_mis", 64'(b16.misaligned), 64'h0);
        check("w16_wrap_und", 64'(b16.rasUnderflow), 64'h0);
        check("w16_wrap_cnt", 64'(b16.rasCount), 64'h0);
        b16.en = 0;

        // Randomised run against the model.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        model_step(1, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit          r_rst, r_en, r_br, r_ca, r_re, r_tr;
            logic [31:0] r_addr;
            r_rst  = ($urandom_range(99) == 0);
            r_en   = ($urandom_range(9) != 0);
            r_tr   = ($urandom_range(29) == 0);
            r_ca   = ($urandom_range(3) == 0);
            r_re   = ($urandom_range(3) == 0);
            r_br   = ($urandom_range(3) == 0);
            r_addr = $urandom;
            if ($urandom_range(1) == 0) r_addr[1:0] = 2'b00;
            rst = r_rst;
            drive(r_en, r_br, r_ca, r_re, r_tr, r_addr);
            tick();
            model_step(r_rst, r_en, r_br, r_ca, r_re, r_tr, r_addr);
            check($sformatf("rnd%0d_pc", i), 64'(b32.pc), 64'(m_pc));
            check($sformatf("rnd%0d_pcplus", i), 64'(b32.pcPlus), 64'(m_pc + 32'd4));
            check($sformatf("rnd%0d_cnt", i), 64'(b32.rasCount), 64'(m_ras.size()));
            check($sformatf("rnd%0d_und", i), 64'(b32.rasUnderflow), 64'(m_und));
            check($sformatf("rnd%0d_mis", i), 64'(b32.misaligned), 64'(m_mis));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
